// File: rtl/mc_control.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute/writeback.
// Optional macro MC_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP (state 12) until reset.
module mc_control #(
    parameter logic [3:0] ALU_NOP = 4'b1111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic [1:0] PCSource,
    output logic       pc_en,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPE   = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI    = 4'd10,
        S_ADDIWB  = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1110;

    state_t state_r;
    state_t state_nxt;
    logic   pc_write;
    logic   pc_write_cond;

    function automatic logic [3:0] funct_to_alu(input logic [5:0] f);
        case (f)
            6'h20:   funct_to_alu = ALU_ADD;
            6'h22:   funct_to_alu = ALU_SUB;
            6'h24:   funct_to_alu = ALU_AND;
            6'h27:   funct_to_alu = ALU_NOR;
            6'h2A:   funct_to_alu = ALU_SLT;
            6'h00:   funct_to_alu = ALU_SLL;
            default: funct_to_alu = ALU_NOP;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_FETCH;
        else       state_r <= state_nxt;
    end

    // NOTE: each combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = S_FETCH;
        case (state_r)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = S_RTYPE;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDI;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_nxt = S_TRAP;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_RTYPE:  state_nxt = S_RTYPEWB;
            S_ADDI:   state_nxt = S_ADDIWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_nxt = S_TRAP;
`endif
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Reset overrides the state decode so an aborted instruction can never emit a write.
    always_comb begin
        ALUControl    = ALU_NOP;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        PCSource      = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal       = 1'b0;
        if (!reset) begin
            case (state_r)
                S_FETCH: begin
                    MemRead    = 1'b1;
                    IRWrite    = 1'b1;
                    ALUSrcB    = 2'b01;
                    ALUControl = ALU_ADD;
                    pc_write   = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = ALU_ADD;
                end
                S_MEMADR, S_ADDI: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_ADD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_RTYPE: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = funct_to_alu(funct);
                end
                S_RTYPEWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA       = 1'b1;
                    ALUControl    = ALU_SUB;
                    pc_write_cond = 1'b1;
                    PCSource      = 2'b01;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    PCSource = 2'b10;
                end
                S_ADDIWB: RegWrite = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP:   illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = state_r;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed literal checks plus randomized instruction
// streams compared every cycle against an instruction-level sequence model.
module tb_mc_control;

    localparam logic [3:0] NOP = 4'b1111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic [3:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite;
    logic [1:0] PCSource;
    logic       pc_en;
    logic [3:0] state;
    logic       illegal;

    always #5 clk = ~clk;

    mc_control #(.ALU_NOP(NOP)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .PCSource(PCSource), .pc_en(pc_en), .state(state), .illegal(illegal)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instruction is the list of states that follow DECODE; the FSM returns to FETCH after it.
    int m_state = 0;
    int m_q[$];
    bit chk_en = 1'b0;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0;
            m_q.delete();
            chk_en  = 1'b1;
        end else if (chk_en) begin
            if (m_state == 1) begin
                case (opcode)
                    6'h00:   m_q = '{6, 7};
                    6'h23:   m_q = '{2, 3, 4};
                    6'h2B:   m_q = '{2, 5};
                    6'h04:   m_q = '{8};
                    6'h02:   m_q = '{9};
                    6'h08:   m_q = '{10, 11};
                    default: if (TRAP_EN) m_q = '{12};
                endcase
            end
            if (m_state == 12)        m_state = 12;
            else if (m_state == 0)    m_state = 1;
            else if (m_q.size() > 0)  m_state = m_q.pop_front();
            else                      m_state = 0;
        end
    end

    function automatic logic [3:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            6'h00:   return 4'b1110;
            default: return NOP;
        endcase
    endfunction

    // Output table per state, packed as
    // {ALUControl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, PCSource, pc_en, state, illegal}
    function automatic logic [21:0] exp_out(input int st, input logic [5:0] f, input logic z, input logic r);
        logic [3:0] alu = NOP;
        logic       sa = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, pe = 0, ill = 0;
        logic [1:0] sb = 0, pcs = 0;
        if (!r) begin
            case (st)
                0:  begin mr = 1; irw = 1; sb = 2'b01; alu = 4'b0010; pe = 1; end
                1:  begin sb = 2'b11; alu = 4'b0010; end
                2:  begin sa = 1; sb = 2'b10; alu = 4'b0010; end
                3:  begin mr = 1; iord = 1; end
                4:  begin rw = 1; m2r = 1; end
                5:  begin mw = 1; iord = 1; end
                6:  begin sa = 1; alu = alu_of_funct(f); end
                7:  begin rd = 1; rw = 1; end
                8:  begin sa = 1; alu = 4'b0110; pcs = 2'b01; pe = z; end
                9:  begin pe = 1; pcs = 2'b10; end
                10: begin sa = 1; sb = 2'b10; alu = 4'b0010; end
                11: rw = 1;
                12: ill = 1;
                default: ;
            endcase
        end
        return {alu, sa, sb, iord, mr, mw, irw, m2r, rd, rw, pcs, pe, st[3:0], ill};
    endfunction

    wire [21:0] act_vec = {ALUControl, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                           MemtoReg, RegDst, RegWrite, PCSource, pc_en, state, illegal};

    always @(negedge clk) begin
        if (chk_en) check("model_cycle", {10'd0, act_vec}, {10'd0, exp_out(m_state, funct, zero, reset)});
    end

    // Apply inputs just after a rising edge, return at the following falling edge.
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z);
        @(posedge clk);
        #1;
        reset = r; opcode = op; funct = fn; zero = z;
        @(negedge clk);
    endtask

    logic [5:0] ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h27, 6'h2A, 6'h00};

    initial begin
        logic [5:0] cur_op;
        logic [5:0] op, fn;
        bit         r, known;

        // Reset for two cycles, then release.
        cyc(1, 6'h00, 6'h2A, 0);
        check("rst1_alu", ALUControl, NOP);
        check("rst1_strobes", {MemRead, IRWrite, MemWrite, RegWrite, IorD, pc_en, illegal}, 0);
        cyc(1, 6'h00, 6'h2A, 0);
        check("rst2_alu", ALUControl, NOP);
        check("rst2_strobes", {MemRead, IRWrite, MemWrite, RegWrite, IorD, pc_en, illegal}, 0);
        cyc(0, 6'h00, 6'h2A, 0);
        check("rel_state", state, 0);
        check("rel_fetch", {MemRead, IRWrite, pc_en}, 3'b111);

        // R-type SLT: 0,1,6,7,0
        cyc(0, 6'h00, 6'h2A, 0); check("rt_s1", state, 1);
        cyc(0, 6'h00, 6'h2A, 0); check("rt_s6", state, 6);
        check("rt_slt", ALUControl, 4'b0111);
        cyc(0, 6'h00, 6'h2A, 0); check("rt_s7", state, 7);
        check("rt_wb", {RegDst, RegWrite}, 2'b11);
        cyc(0, 6'h23, 6'h00, 0); check("rt_s0", state, 0);

        // lw: 0,1,2,3,4,0
        cyc(0, 6'h23, 6'h00, 0); check("lw_s1", state, 1);
        cyc(0, 6'h23, 6'h00, 0); check("lw_s2", state, 2);
        cyc(0, 6'h23, 6'h00, 0); check("lw_s3", state, 3);
        check("lw_rd", {IorD, MemRead}, 2'b11);
        cyc(0, 6'h23, 6'h00, 0); check("lw_s4", state, 4);
        check("lw_wb", {MemtoReg, RegWrite}, 2'b11);
        cyc(0, 6'h04, 6'h00, 1); check("lw_s0", state, 0);

        // beq taken then not taken
        cyc(0, 6'h04, 6'h00, 1); check("beqt_s1", state, 1);
        cyc(0, 6'h04, 6'h00, 1); check("beqt_s8", state, 8);
        check("beqt_pcen", pc_en, 1);
        check("beqt_alu", ALUControl, 4'b0110);
        cyc(0, 6'h04, 6'h00, 0); check("beqt_s0", state, 0);
        cyc(0, 6'h04, 6'h00, 0); check("beqn_s1", state, 1);
        cyc(0, 6'h04, 6'h00, 0); check("beqn_s8", state, 8);
        check("beqn_pcen", pc_en, 0);
        check("beqn_alu", ALUControl, 4'b0110);
        cyc(0, 6'h2B, 6'h00, 0); check("beqn_s0", state, 0);

        // sw aborted by reset while in MEMWR
        cyc(0, 6'h2B, 6'h00, 0); check("sw_s1", state, 1);
        cyc(0, 6'h2B, 6'h00, 0); check("sw_s2", state, 2);
        cyc(1, 6'h2B, 6'h00, 0); check("sw_s5", state, 5);
        check("sw_rst_mw", MemWrite, 0);
        cyc(0, 6'h3F, 6'h00, 0); check("sw_after_state", state, 0);
        check("sw_after_mw", MemWrite, 0);

        // unknown opcode
        cyc(0, 6'h3F, 6'h00, 0); check("ill_s1", state, 1);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            cyc(0, 6'h3F, 6'h00, 0);
            check("trap_state", state, 12);
            check("trap_illegal", illegal, 1);
        end
        cyc(1, 6'h00, 6'h00, 0); check("trap_rst_ill", illegal, 0);
        cyc(0, 6'h00, 6'h00, 0); check("trap_rst_s0", state, 0);
`else
        cyc(0, 6'h3F, 6'h00, 0); check("ill_s0", state, 0);
        check("ill_flag", illegal, 0);
        cyc(0, 6'h3F, 6'h00, 0); check("ill_s1b", state, 1);
        check("ill_flag2", illegal, 0);
`endif

        // Randomized instruction stream; opcode/funct are scrambled outside their sampling states.
        cur_op = 6'h00;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (m_state == 0) begin
                if ($urandom_range(0, 6) == 6) begin
                    do begin
                        cur_op = 6'($urandom);
                        known = 1'b0;
                        for (int k = 0; k < 6; k++) if (ops[k] == cur_op) known = 1'b1;
                    end while (known);
                end else begin
                    cur_op = ops[$urandom_range(0, 5)];
                end
            end
            op = 6'($urandom);
            fn = 6'($urandom);
            if (m_state == 1 || m_state == 2) op = cur_op;
            if (m_state == 6 && $urandom_range(0, 1) == 1) fn = fns[$urandom_range(0, 5)];
            r = ($urandom_range(0, 59) == 0) || (m_state == 12 && $urandom_range(0, 3) == 0);
            reset = r; opcode = op; funct = fn; zero = 1'($urandom);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
